// File: rtl/magic_matcher.sv
// magic_matcher: Dice-ratio template classifier over a latched binary image,
// streaming one mask-ROM row per cycle and picking the best class by argmax.
// Ports: i_clk, i_rst_n (async, active low), i_start, i_abort, i_image,
//   o_mask_addr / i_mask_row (1-cycle ROM), o_busy, o_valid, o_digit,
//   o_son / o_mom (winner's Dice numerator/denominator), o_reject.
module magic_matcher #(
  parameter int IMG_W       = 30,
  parameter int IMG_H       = 30,
  parameter int NUM_CLASSES = 10,
  parameter int THR_NUM     = 1,
  parameter int THR_DEN     = 2,
  localparam int ROW_W      = $clog2(IMG_H),
  localparam int CLS_W      = $clog2(NUM_CLASSES),
  localparam int SCORE_W    = $clog2(2*IMG_W*IMG_H+1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [IMG_W*IMG_H-1:0]       i_image,
  output logic [ROW_W-1:0]             o_mask_addr,
  input  logic [NUM_CLASSES*IMG_W-1:0] i_mask_row,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic [CLS_W-1:0]             o_digit,
  output logic [SCORE_W-1:0]           o_son,
  output logic [SCORE_W-1:0]           o_mom,
  output logic                         o_reject
);

  localparam int PW = 2*SCORE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ACCUM, S_ARGMAX, S_DONE
  } state_t;

  state_t                 state;
  logic [IMG_W*IMG_H-1:0] img_q;
  logic [ROW_W-1:0]       row_q;
  logic [CLS_W-1:0]       k_q;
  logic [SCORE_W-1:0]     son_q [NUM_CLASSES];
  logic [SCORE_W-1:0]     mom_q [NUM_CLASSES];
  logic [CLS_W-1:0]       best_q;
  logic [SCORE_W-1:0]     bson_q;
  logic [SCORE_W-1:0]     bmom_q;

  function automatic logic [SCORE_W-1:0] popcnt(
    input logic [IMG_W-1:0] v
  );
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < IMG_W; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

  logic [IMG_W-1:0]   img_rows [IMG_H];
  logic [IMG_W-1:0]   img_row;
  logic [SCORE_W-1:0] pc_img;
  logic [SCORE_W-1:0] son_inc [NUM_CLASSES];
  logic [SCORE_W-1:0] mom_inc [NUM_CLASSES];

  always_comb begin
    for (int y = 0; y < IMG_H; y++)
      img_rows[y] = img_q[y*IMG_W +: IMG_W];
    img_row = img_rows[row_q];
    pc_img  = popcnt(img_row);
    for (int c = 0; c < NUM_CLASSES; c++) begin
      son_inc[c] = popcnt(img_row & i_mask_row[c*IMG_W +: IMG_W]) << 1;
      mom_inc[c] = pc_img + popcnt(i_mask_row[c*IMG_W +: IMG_W]);
    end
  end

  // Cross-multiplied Dice comparison; a zero denominator counts as 1 so
  // empty classes compare as score 0 instead of dividing by zero.
  logic [SCORE_W-1:0] son_k, mom_k, mk, mb;
  logic [PW-1:0]      lhs, rhs;
  logic               take;
  logic [CLS_W-1:0]   w_idx;
  logic [SCORE_W-1:0] w_son, w_mom;
  logic               w_rej;

  always_comb begin
    son_k = son_q[k_q];
    mom_k = mom_q[k_q];
    mk    = (mom_k  == '0) ? SCORE_W'(1) : mom_k;
    mb    = (bmom_q == '0) ? SCORE_W'(1) : bmom_q;
    lhs   = PW'(son_k)  * PW'(mb);
    rhs   = PW'(bson_q) * PW'(mk);
    take  = lhs > rhs;
    w_idx = take ? k_q   : best_q;
    w_son = take ? son_k : bson_q;
    w_mom = take ? mom_k : bmom_q;
    w_rej = (w_mom == '0) |
            (PW'(w_son) * PW'(THR_DEN) < PW'(w_mom) * PW'(THR_NUM));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      img_q       <= '0;
      row_q       <= '0;
      k_q         <= '0;
      best_q      <= '0;
      bson_q      <= '0;
      bmom_q      <= '0;
      o_mask_addr <= '0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_digit     <= '0;
      o_son       <= '0;
      o_mom       <= '0;
      o_reject    <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        son_q[c] <= '0;
        mom_q[c] <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      if (state != S_IDLE && i_abort) begin
        state       <= S_IDLE;
        o_busy      <= 1'b0;
        o_mask_addr <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (i_start) begin
              img_q       <= i_image;
              state       <= S_FETCH;
              o_busy      <= 1'b1;
              o_mask_addr <= '0;
              for (int c = 0; c < NUM_CLASSES; c++) begin
                son_q[c] <= '0;
                mom_q[c] <= '0;
              end
            end
          end
          S_FETCH: begin
            state       <= S_ACCUM;
            row_q       <= '0;
            o_mask_addr <= ROW_W'(1);
          end
          S_ACCUM: begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
              son_q[c] <= son_q[c] + son_inc[c];
              mom_q[c] <= mom_q[c] + mom_inc[c];
            end
            // Address runs one row ahead of the data it will return.
            if (int'(row_q) + 2 <= IMG_H - 1)
              o_mask_addr <= row_q + ROW_W'(2);
            else
              o_mask_addr <= ROW_W'(IMG_H - 1);
            if (row_q == ROW_W'(IMG_H - 1)) begin
              state <= S_ARGMAX;
              k_q   <= '0;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
          S_ARGMAX: begin
            if (k_q == '0) begin
              best_q <= '0;
              bson_q <= son_q[0];
              bmom_q <= mom_q[0];
            end else begin
              best_q <= w_idx;
              bson_q <= w_son;
              bmom_q <= w_mom;
            end
            // Result registers load on the last compare so o_valid
            // coincides with the DONE cycle.
            if (k_q == CLS_W'(NUM_CLASSES - 1)) begin
              state    <= S_DONE;
              o_digit  <= w_idx;
              o_son    <= w_son;
              o_mom    <= w_mom;
              o_reject <= w_rej;
              o_valid  <= 1'b1;
            end else begin
              k_q <= k_q + CLS_W'(1);
            end
          end
          S_DONE: begin
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_mask_addr <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_magic_matcher.sv
// tb_magic_matcher: directed scoreboard bench for magic_matcher.
// Stimulus pushes expected results; a negedge monitor pops on o_valid.
module tb_magic_matcher;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int NC = 10;
  localparam int SW = 11;
  localparam int CW = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W*H-1:0]  img = '0;
  logic [RW-1:0]   addr;
  logic [NC*W-1:0] mrow = '0;
  logic          busy, valid, rej;
  logic [CW-1:0] digit;
  logic [SW-1:0] son, mom;

  always #5 clk = ~clk;

  magic_matcher dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_image(img), .o_mask_addr(addr), .i_mask_row(mrow),
    .o_busy(busy), .o_valid(valid), .o_digit(digit),
    .o_son(son), .o_mom(mom), .o_reject(rej)
  );

  logic [NC*W-1:0] rom [H];
  always @(posedge clk)
    mrow <= (int'(addr) < H) ? rom[addr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] d;
    logic [SW-1:0] s;
    logic [SW-1:0] m;
    logic          r;
    int            t;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid at %0d expected none",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("digit", digit, e.d);
        chk("son", son, e.s);
        chk("mom", mom, e.m);
        chk("reject", rej, e.r);
        chk("valid_cycle", cyc, e.t);
      end
    end
  end

  task automatic clear_all();
    img = '0;
    for (int y = 0; y < H; y++) rom[y] = '0;
  endtask

  task automatic img_rect(int y0, int y1, int x0, int x1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y*W+x] = 1'b1;
  endtask

  task automatic mask_rect(int c, int y0, int y1, int x0, int x1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) rom[y][c*W+x] = 1'b1;
  endtask

  task automatic kick(output int s0);
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_c1", busy, 1);
  endtask

  task automatic launch(int d, int s, int m, int r, output int s0);
    exp_t e;
    kick(s0);
    e.d = CW'(d); e.s = SW'(s); e.m = SW'(m); e.r = r[0];
    e.t = s0 + H + NC + 2;
    sb.push_back(e);
  endtask

  task automatic wait_to(int s0, int n);
    while (cyc < s0 + n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic setup_match3();
    clear_all();
    img_rect(0, 9, 0, 9);
    for (int c = 0; c < NC; c++)
      if (c == 3) mask_rect(c, 0, 9, 0, 9);
      else mask_rect(c, 20, 29, 20, 29);
  endtask

  task automatic setup_overlap5();
    clear_all();
    img_rect(0, 9, 0, 9);
    mask_rect(5, 6, 15, 0, 9);
  endtask

  initial begin
    int s0;
    clear_all();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_digit", digit, 0);
    chk("rst_son", son, 0);
    chk("rst_mom", mom, 0);
    chk("rst_reject", rej, 0);
    chk("rst_addr", addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // empty image: all zero scores, class 0 wins with its own 10 pixels
    clear_all();
    for (int c = 0; c < NC; c++) mask_rect(c, 0, 9, c, c);
    launch(0, 0, 10, 1, s0);
    drain();

    setup_match3();
    launch(3, 200, 200, 0, s0);
    drain();

    // stray start mid-run must not disturb anything
    setup_match3();
    launch(3, 200, 200, 0, s0);
    wait_to(s0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // abort at cycle 15; previous result must survive
    kick(s0);
    wait_to(s0, 15);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("held_digit", digit, 3);
    chk("held_son", son, 200);
    chk("held_mom", mom, 200);
    chk("held_reject", rej, 0);

    // identical masks on classes 2 and 7: lower index wins the tie
    clear_all();
    img_rect(0, 9, 0, 9);
    mask_rect(2, 0, 9, 0, 9);
    mask_rect(7, 0, 9, 0, 9);
    launch(2, 200, 200, 0, s0);
    drain();

    setup_overlap5();
    launch(5, 80, 200, 1, s0);
    drain();

    // reset during ARGMAX clears outputs at once
    setup_match3();
    kick(s0);
    wait_to(s0, H + 3);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_digit", digit, 0);
    chk("mrst_son", son, 0);
    chk("mrst_mom", mom, 0);
    chk("mrst_reject", rej, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);

    setup_overlap5();
    launch(5, 80, 200, 1, s0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/magic_matcher.md
# magic_matcher

Parametrised template-matching classifier for the handwriting path: scores a latched IMG_H×IMG_W binary image against NUM_CLASSES mask templates using the Dice ratio 2·|A∩M| / (|A|+|M|), then selects the best class with a sequential argmax. It processes one image row per cycle from an external mask ROM, supports abort, reports the winning score and flags low-confidence results. It sits between the drawing-canvas capture logic and the digit display.

## Interface
- IMG_W, 30: image width in pixels
- IMG_H, 30: image height in rows
- NUM_CLASSES, 10: number of templates/classes (≥2)
- THR_NUM, 1 / THR_DEN, 2: reject threshold, as the ratio THR_NUM/THR_DEN
- Derived: ROW_W = clog2(IMG_H), CLS_W = clog2(NUM_CLASSES), SCORE_W = clog2(2·IMG_W·IMG_H+1) (11 at defaults)
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled only in IDLE
- i_abort  in  1  return to IDLE without a result
- i_image  in  IMG_W·IMG_H  pixel (x,y) at bit y·IMG_W+x; latched at start
- o_mask_addr  out  ROW_W  mask ROM row address
- i_mask_row  in  NUM_CLASSES·IMG_W  row data, one cycle after address; class c pixel x at bit c·IMG_W+x
- o_busy  out  1  high in every non-IDLE state
- o_valid  out  1  one-cycle pulse when result is updated
- o_digit  out  CLS_W  winning class
- o_son, o_mom  out  SCORE_W each  winner's numerator 2·|A∩M| and denominator |A|+|M|
- o_reject  out  1  winner below threshold

## Operation
- States: IDLE → FETCH → ACCUM → ARGMAX → DONE → IDLE.
- IDLE: when i_start=1, latch i_image, clear all son[c]/mom[c], go to FETCH.
- FETCH (1 cycle): o_mask_addr=0.
- ACCUM (IMG_H cycles, row counter r=0..IMG_H-1): i_mask_row holds row r; o_mask_addr=r+1 (row IMG_H-1 on the final cycle, where it is don't-care). Per class c: son[c] += 2·popcount(img_row & mask_row_c); mom[c] += popcount(img_row) + popcount(mask_row_c). After r=IMG_H-1, go to ARGMAX.
- ARGMAX (NUM_CLASSES cycles): best initialised to class 0; cycle k=1..NUM_CLASSES-1 compares class k against best. Replace only if son[k]·m_best > son_best·m[k], where m = max(mom,1). Products are 2·SCORE_W bits with no truncation. Ties keep the lower index. The first cycle loads class 0.
- DONE (1 cycle): register o_digit, o_son, o_mom (raw mom of the winner), and o_reject = (mom==0) | (son·THR_DEN < mom·THR_NUM). Pulse o_valid, go to IDLE.
- Result outputs hold until the next DONE.
- i_start outside IDLE is ignored.
- i_abort in any non-IDLE state has priority: next state is IDLE, no o_valid, result outputs unchanged. It has no effect in IDLE, even together with i_start.
- Accumulators cannot overflow by construction; their maximum is 2·IMG_W·IMG_H.

## Timing
- Reset values: state IDLE; o_busy=0, o_valid=0, o_digit=0, o_son=0, o_mom=0, o_reject=0, o_mask_addr=0; accumulators cleared.
- Reset asserted mid-operation aborts immediately; no o_valid follows.
- Cycle numbering: i_start sampled in cycle 0.
  - FETCH occupies cycle 1.
  - ACCUM occupies cycles 2..IMG_H+1.
  - ARGMAX occupies cycles IMG_H+2..IMG_H+NUM_CLASSES+1.
  - o_valid is high in cycle IMG_H+NUM_CLASSES+2, which is cycle 42 at defaults.
- o_busy is high from cycle 1 through the DONE cycle.
- The next i_start is accepted in the cycle after DONE.
- Mask ROM latency is exactly one cycle; the block never stalls.

## Test plan
- All-zero image, masks with non-empty rows → o_digit=0 (all scores 0, lowest-index tie), o_son=0, o_reject=1; o_valid exactly at cycle 42.
- Image equal to mask 3 (100 pixels set), other masks disjoint from it → o_digit=3, o_son=200, o_mom=200, o_reject=0.
- Classes 2 and 7 given identical masks matching the image, all others empty → o_digit=2.
- Image of 100 pixels overlapping mask 5 (100 pixels) in 40 pixels, best among all classes → o_digit=5, o_son=80, o_mom=200, o_reject=1 (0.4 < 0.5).
- i_start pulsed at cycle 10 of a run → ignored; result timing and value unchanged. i_abort at cycle 15 → o_busy=0 at cycle 16, no o_valid, previous result held.
- i_rst_n asserted during ARGMAX → all outputs 0 immediately; a subsequent start produces a correct result.
